// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } seq_state_t;

  // Byte distance between consecutive instruction words.
  localparam int unsigned PC_INCR = 4;

  // Low address bits that must be zero for a word-aligned target.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // True when a target's low bits would break word alignment.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: load-enabled, asynchronously reset to RESET_PC.
module pc_reg #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture the next PC only when the sequencer commits an update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch controller: owns the PC, fetches over a req/ack handshake,
// presents the instruction to decode and picks the next PC.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned       MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             halt,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] pc,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             fault
);

  // Counter must hold values up to MAX_WAIT-1 (MAX_WAIT is expected >= 1).
  localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  seq_state_t       state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] next_pc;
  logic             redirect;
  logic             misaligned;
  logic             pc_load;

  pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pc_load),
    .d       (next_pc),
    .q       (pc)
  );

  // Next-PC select: jump beats branch beats sequential; flag bad alignment.
  always_comb begin
    redirect   = jmp | br_taken;
    target     = jmp ? jmp_target : br_target;
    pc_seq     = pc + WIDTH'(PC_INCR);
    next_pc    = redirect ? target : pc_seq;
    misaligned = redirect && is_misaligned(target[1:0]);
  end

  // PC commits only on a non-stalled ISSUE with an aligned destination.
  always_comb begin
    pc_load = (state == ST_ISSUE) && !stall && !misaligned;
  end

  // State transitions; stall freezes ISSUE regardless of halt or redirects.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          state_next = ST_ISSUE;
        end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
          state_next = ST_FAULT;
        end
      end
      ST_ISSUE: begin
        if (!stall) begin
          if (misaligned) begin
            state_next = ST_FAULT;
          end else if (halt) begin
            state_next = ST_HALTED;
          end else begin
            state_next = ST_FETCH;
          end
        end
      end
      ST_HALTED: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counts consecutive FETCH cycles without an ack; zero everywhere else.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if ((state == ST_FETCH) && !imem_ack) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Instruction latch, loaded on the acknowledged fetch edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr <= '0;
    end else if ((state == ST_FETCH) && imem_ack) begin
      instr <= imem_rdata;
    end
  end

  // Registered fault flag; FAULT has no exit besides reset, so it stays set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault <= 1'b0;
    end else begin
      fault <= (state_next == ST_FAULT);
    end
  end

  // Handshake and decode qualifiers follow the registered state directly, so
  // reset drops imem_req without waiting for a clock.
  always_comb begin
    imem_req    = (state == ST_FETCH);
    instr_valid = (state == ST_ISSUE);
    imem_addr   = pc;
  end

endmodule
